// File: rtl/smi_flit_scale_down.sv
// ---------------------------------------------------------------------------
// smi_flit_scale_down
//
// Serialises a FlitWidth-byte SMI stream into OutWidth-byte chunks, where
// OutWidth = FlitWidth >> ScaleLog2, in a single stage. On the final flit of
// a frame only the chunks that carry valid bytes are emitted, and the last
// of them carries the end-of-frame byte count relative to that chunk.
//
// Storage: an input holding register, a shifter (flit + eofc + chunk index +
// chunk count) and an output register holding one chunk. When the path is
// free an incoming flit bypasses the holding register and goes straight into
// the shifter, which gives a two-cycle accept-to-output latency.
//
// Ports:
//   clk          system clock, rising edge
//   srst         synchronous active-high reset
//   smiInReady   input flit valid
//   smiInEofc    0 = not final, 1..FlitWidth = valid byte count of final flit
//   smiInData    input flit, byte 0 in bits [7:0]
//   smiInStop    input backpressure (registered: holding register full)
//   smiOutReady  output chunk valid (registered)
//   smiOutEofc   output end-of-frame count (registered)
//   smiOutData   output chunk (registered)
//   smiOutStop   output backpressure
// ---------------------------------------------------------------------------
module smi_flit_scale_down #(
  parameter int FlitWidth = 8,
  parameter int ScaleLog2 = 3
) (
  input  logic                                  clk,
  input  logic                                  srst,
  input  logic                                  smiInReady,
  input  logic [7:0]                            smiInEofc,
  input  logic [FlitWidth*8-1:0]                smiInData,
  output logic                                  smiInStop,
  output logic                                  smiOutReady,
  output logic [7:0]                            smiOutEofc,
  output logic [(FlitWidth >> ScaleLog2)*8-1:0] smiOutData,
  input  logic                                  smiOutStop
);

  localparam int OutWidth  = FlitWidth >> ScaleLog2;
  localparam int FlitBits  = FlitWidth * 8;
  localparam int OutBits   = OutWidth * 8;
  localparam int NumChunks = 1 << ScaleLog2;
  localparam int CntW      = ScaleLog2 + 1;
  localparam int OutLog2   = $clog2(OutWidth);
  localparam logic [7:0] FlitW8 = 8'(FlitWidth);

  // Holding register
  logic                holdValid_q, holdValid_d;
  logic [7:0]          holdEofc_q, holdEofc_d;
  logic [FlitBits-1:0] holdData_q, holdData_d;

  // Shifter
  logic                shValid_q, shValid_d;
  logic [7:0]          shEofc_q, shEofc_d;
  logic [FlitBits-1:0] shData_q, shData_d;
  logic [CntW-1:0]     shIdx_q, shIdx_d;
  logic [CntW-1:0]     shN_q, shN_d;

  // Output register
  logic                outValid_q, outValid_d;
  logic [7:0]          outEofc_q, outEofc_d;
  logic [OutBits-1:0]  outData_q, outData_d;

  // Handshake and load-source signals
  logic                inFire;
  logic                outFire;
  logic                outCanLoad;
  logic                shLast;
  logic                shFree;
  logic                shLoad;
  logic [7:0]          srcEofc;
  logic [7:0]          srcEofcSat;
  logic [FlitBits-1:0] srcData;
  logic [8:0]          roundUp;
  logic [CntW-1:0]     srcN;
  logic [FlitBits-1:0] shShifted;
  logic [7:0]          chunkOff;
  logic [7:0]          chunkEofc;

  // Handshake decode. The shifter is free when empty or when its last chunk
  // moves into the output register this cycle; the holding register has
  // priority as load source, otherwise a fresh input flit bypasses it.
  // Chunk count is ceil(eofc/OutWidth) on a saturated eofc, or all chunks
  // for a non-final flit.
  always_comb begin
    inFire     = smiInReady & ~holdValid_q;
    outFire    = outValid_q & ~smiOutStop;
    outCanLoad = ~outValid_q | outFire;
    shLast     = shValid_q & (shIdx_q == (shN_q - CntW'(1)));
    shFree     = ~shValid_q | (shLast & outCanLoad);
    shLoad     = shFree & (holdValid_q | inFire);

    srcEofc    = holdValid_q ? holdEofc_q : smiInEofc;
    srcData    = holdValid_q ? holdData_q : smiInData;
    srcEofcSat = (srcEofc > FlitW8) ? FlitW8 : srcEofc;
    roundUp    = {1'b0, srcEofcSat} + 9'(OutWidth - 1);
    srcN       = (srcEofcSat == 8'd0) ? CntW'(NumChunks) : CntW'(roundUp >> OutLog2);

    shShifted  = shData_q >> (int'(shIdx_q) * OutBits);
    chunkOff   = 8'(int'(shIdx_q) * OutWidth);
    chunkEofc  = (shLast && (shEofc_q != 8'd0)) ? (shEofc_q - chunkOff) : 8'd0;
  end

  // Next-state logic for the three storage elements. A last-chunk transfer,
  // a shifter load and an input capture can all happen in the same cycle.
  always_comb begin
    holdValid_d = holdValid_q;
    holdEofc_d  = holdEofc_q;
    holdData_d  = holdData_q;
    shValid_d   = shValid_q;
    shEofc_d    = shEofc_q;
    shData_d    = shData_q;
    shIdx_d     = shIdx_q;
    shN_d       = shN_q;
    outValid_d  = outValid_q;
    outEofc_d   = outEofc_q;
    outData_d   = outData_q;

    if (holdValid_q) begin
      if (shLoad) begin
        holdValid_d = 1'b0;
      end
    end else if (inFire && !shFree) begin
      holdValid_d = 1'b1;
      holdEofc_d  = smiInEofc;
      holdData_d  = smiInData;
    end

    if (shLoad) begin
      shValid_d = 1'b1;
      shEofc_d  = srcEofcSat;
      shData_d  = srcData;
      shIdx_d   = '0;
      shN_d     = srcN;
    end else if (shValid_q && outCanLoad) begin
      if (shLast) begin
        shValid_d = 1'b0;
      end else begin
        shIdx_d = shIdx_q + CntW'(1);
      end
    end

    if (outCanLoad) begin
      outValid_d = shValid_q;
      if (shValid_q) begin
        outEofc_d = chunkEofc;
        outData_d = shShifted[OutBits-1:0];
      end
    end
  end

  // State registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (srst) begin
      holdValid_q <= 1'b0;
      holdEofc_q  <= '0;
      holdData_q  <= '0;
      shValid_q   <= 1'b0;
      shEofc_q    <= '0;
      shData_q    <= '0;
      shIdx_q     <= '0;
      shN_q       <= '0;
      outValid_q  <= 1'b0;
      outEofc_q   <= '0;
      outData_q   <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdEofc_q  <= holdEofc_d;
      holdData_q  <= holdData_d;
      shValid_q   <= shValid_d;
      shEofc_q    <= shEofc_d;
      shData_q    <= shData_d;
      shIdx_q     <= shIdx_d;
      shN_q       <= shN_d;
      outValid_q  <= outValid_d;
      outEofc_q   <= outEofc_d;
      outData_q   <= outData_d;
    end
  end

  assign smiInStop   = holdValid_q;
  assign smiOutReady = outValid_q;
  assign smiOutEofc  = outEofc_q;
  assign smiOutData  = outData_q;

endmodule

// File: tb/tb_smi_flit_scale_down.sv
// ---------------------------------------------------------------------------
// tb_smi_flit_scale_down
//
// Bench for smi_flit_scale_down at FlitWidth=8, ScaleLog2=2 (2-byte chunks).
// Each accepted flit is expanded into its expected chunks by a byte-level
// model and pushed into a queue; a monitor pops and compares on every output
// transfer and checks that outputs hold still while stalled.
// ---------------------------------------------------------------------------
module tb_smi_flit_scale_down;

  localparam int FlitWidth = 8;
  localparam int ScaleLog2 = 2;
  localparam int OutWidth  = FlitWidth >> ScaleLog2;
  localparam int NumChunks = 1 << ScaleLog2;

  logic                   clk = 1'b0;
  logic                   srst;
  logic                   smiInReady;
  logic [7:0]             smiInEofc;
  logic [FlitWidth*8-1:0] smiInData;
  logic                   smiInStop;
  logic                   smiOutReady;
  logic [7:0]             smiOutEofc;
  logic [OutWidth*8-1:0]  smiOutData;
  logic                   smiOutStop;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic [7:0]            eofc;
    logic [OutWidth*8-1:0] data;
  } chunk_t;

  chunk_t expQ[$];

  logic randStop  = 1'b0;
  logic stopForce = 1'b0;
  int   stopPct   = 30;

  smi_flit_scale_down #(
    .FlitWidth(FlitWidth),
    .ScaleLog2(ScaleLog2)
  ) dut (
    .clk(clk),
    .srst(srst),
    .smiInReady(smiInReady),
    .smiInEofc(smiInEofc),
    .smiInData(smiInData),
    .smiInStop(smiInStop),
    .smiOutReady(smiOutReady),
    .smiOutEofc(smiOutEofc),
    .smiOutData(smiOutData),
    .smiOutStop(smiOutStop)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Output backpressure driver: random or forced, updated just after each edge
  initial begin
    smiOutStop = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      smiOutStop = randStop ? ($urandom_range(0, 99) < stopPct) : stopForce;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: split the flit into byte chunks; a final flit keeps only
  // the chunks holding valid bytes and the last one reports its byte count
  task automatic pushFlit(input logic [7:0] eofc, input logic [63:0] data);
    int     nBytes;
    int     n;
    chunk_t c;
    nBytes = (eofc == 8'd0 || eofc > 8'(FlitWidth)) ? FlitWidth : int'(eofc);
    n      = (eofc == 8'd0) ? NumChunks : (nBytes + OutWidth - 1) / OutWidth;
    for (int k = 0; k < n; k++) begin
      c.data = data[k*OutWidth*8 +: OutWidth*8];
      c.eofc = (eofc != 8'd0 && k == n - 1) ? 8'(nBytes - k * OutWidth) : 8'd0;
      expQ.push_back(c);
    end
  endtask

  // Present one flit and hold it until accepted; leaves smiInReady high so a
  // following call continues back-to-back
  task automatic applyStimulus(input logic [7:0] eofc, input logic [63:0] data);
    int waitCnt;
    bit done;
    waitCnt = 0;
    done    = 1'b0;
    @(posedge clk);
    #1;
    smiInReady = 1'b1;
    smiInEofc  = eofc;
    smiInData  = data;
    while (!done) begin
      @(negedge clk);
      if (!smiInStop) begin
        pushFlit(eofc, data);
        done = 1'b1;
      end else begin
        waitCnt++;
        if (waitCnt > 300) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL acceptTimeout: smiInStop still %b, expected 0", smiInStop);
          smiInReady = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    smiInReady = 1'b0;
  endtask

  // Wait (bounded) until every expected chunk has been seen
  task automatic drain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drainTimeout: %0d chunks outstanding, expected 0", expQ.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compare every output transfer against the scoreboard and check
  // the output register holds steady across stalled cycles
  logic                  stalledPrev = 1'b0;
  logic [7:0]            heldEofc;
  logic [OutWidth*8-1:0] heldData;

  always @(negedge clk) begin
    chunk_t c;
    if (srst) begin
      stalledPrev = 1'b0;
    end else begin
      if (stalledPrev) begin
        checkOutput("stallReady", 64'(smiOutReady), 64'(1'b1));
        checkOutput("stallEofc", 64'(smiOutEofc), 64'(heldEofc));
        checkOutput("stallData", 64'(smiOutData), 64'(heldData));
      end
      if (smiOutReady && !smiOutStop) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL extraChunk: got data %h eofc %0d, expected no chunk", smiOutData, smiOutEofc);
        end else begin
          c = expQ.pop_front();
          checkOutput("chunkData", 64'(smiOutData), 64'(c.data));
          checkOutput("chunkEofc", 64'(smiOutEofc), 64'(c.eofc));
        end
      end
      stalledPrev = smiOutReady && smiOutStop;
      heldEofc    = smiOutEofc;
      heldData    = smiOutData;
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence of directed and randomized scenarios
  initial begin
    int cnt;
    int guard;
    int r;
    logic [7:0] e;

    srst       = 1'b1;
    smiInReady = 1'b0;
    smiInEofc  = '0;
    smiInData  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInStop", 64'(smiInStop), 64'd0);
    checkOutput("rstOutReady", 64'(smiOutReady), 64'd0);
    checkOutput("rstOutEofc", 64'(smiOutEofc), 64'd0);
    checkOutput("rstOutData", 64'(smiOutData), 64'd0);
    @(posedge clk);
    #1;
    srst = 1'b0;

    // Single non-final flit into an empty pipe: chunk 0 two cycles after accept
    applyStimulus(8'd0, 64'h0807060504030201);
    idleCycle();
    @(negedge clk);
    checkOutput("latencyN1", 64'(smiOutReady), 64'd0);
    @(negedge clk);
    checkOutput("latencyN2", 64'(smiOutReady), 64'd1);
    drain();

    // Short final flit: three chunks, eofc 0,0,1, nothing after
    applyStimulus(8'd5, 64'h8877665544332211);
    idleCycle();
    drain();
    checkOutput("noExtraChunk", 64'(smiOutReady), 64'd0);

    // Back-to-back full flits then a one-byte final flit: 17 contiguous chunks
    cnt = 0;
    guard = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(8'd0, {$urandom, $urandom});
        applyStimulus(8'd1, {$urandom, $urandom});
        idleCycle();
      end
      begin
        do begin
          @(negedge clk);
          guard++;
        end while (!smiOutReady && guard < 50);
        while (smiOutReady && cnt < 40) begin
          cnt++;
          @(negedge clk);
        end
      end
    join
    checkOutput("contiguousRun", 64'(cnt), 64'd17);
    drain();

    // Backpressure mid-flit with a second flit waiting in the holding register
    applyStimulus(8'd0, {$urandom, $urandom});
    applyStimulus(8'd0, {$urandom, $urandom});
    idleCycle();
    stopForce = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("inStopWhileStalled", 64'(smiInStop), 64'd1);
    @(posedge clk);
    #1;
    stopForce = 1'b0;
    drain();

    // Reset while a frame is partly emitted and another flit is held
    stopForce = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(8'd0, {$urandom, $urandom});
    applyStimulus(8'd0, {$urandom, $urandom});
    idleCycle();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    srst = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    srst = 1'b0;
    stopForce = 1'b0;
    @(negedge clk);
    checkOutput("postRstOutReady", 64'(smiOutReady), 64'd0);
    checkOutput("postRstInStop", 64'(smiInStop), 64'd0);
    applyStimulus(8'd0, 64'hF0E0D0C0B0A09080);
    idleCycle();
    drain();

    // eofc above FlitWidth saturates to a full final flit
    applyStimulus(8'd12, 64'h1122334455667788);
    applyStimulus(8'd255, 64'h0123456789ABCDEF);
    idleCycle();
    drain();

    // Randomized traffic with random backpressure and gaps
    randStop = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) e = 8'd0;
      else if (r < 8) e = 8'($urandom_range(1, FlitWidth));
      else e = 8'($urandom_range(FlitWidth + 1, 255));
      applyStimulus(e, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) idleCycle();
    end
    idleCycle();
    drain();
    randStop = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("finalQueueEmpty", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
